// File: rtl/sonar_pkg.sv
// Shared types and constants for the ultrasound echo receive path.
// The result struct is what travels through the single-entry result slot.
package sonar_pkg;

    localparam int ECHO_SAMPLE_W = 12;
    localparam int ECHO_TOF_W    = 32;

    localparam logic [ECHO_TOF_W-1:0] TOF_SAT = '1;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        LISTEN,
        PEAK
    } echo_state_t;

    typedef struct packed {
        logic [ECHO_TOF_W-1:0]    tof;
        logic [ECHO_SAMPLE_W-1:0] peak;
        logic                     hit;
    } echo_result_t;

    function automatic logic [ECHO_SAMPLE_W-1:0] maxSample(
        input logic [ECHO_SAMPLE_W-1:0] a,
        input logic [ECHO_SAMPLE_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tof_result_slot.sv
// One-entry valid/ready holding register for measurement results.
// A push into a full, unacknowledged slot is dropped and flagged as a sticky overrun.
module tof_result_slot #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         overrun_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;
    logic         ovr_q,   ovr_d;

    // An accept frees the slot in the same cycle, so a simultaneous push still lands.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (push_i) begin
            if (!valid_q || ready_i) begin
                valid_d = 1'b1;
                data_d  = data_i;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/echo_tof_detector.sv
// Time-of-flight echo detector: blanks the ringdown after each burst, then finds the first
// echo using hysteresis thresholds and a minimum run width, reporting TOF and peak amplitude.
module echo_tof_detector
    import sonar_pkg::*;
#(
    parameter int SAMPLE_W = ECHO_SAMPLE_W,
    parameter int TOF_W    = ECHO_TOF_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tx_start,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [TOF_W-1:0]    blank_len,
    input  logic [TOF_W-1:0]    max_range,
    input  logic [SAMPLE_W-1:0] thr_hi,
    input  logic [SAMPLE_W-1:0] thr_lo,
    input  logic [7:0]          min_width,
    output logic                busy,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [TOF_W-1:0]    res_tof,
    output logic [SAMPLE_W-1:0] res_peak,
    output logic                res_hit,
    output logic                overrun
);

    echo_state_t         state_q, state_d;
    logic [TOF_W-1:0]    tof_q, tof_d;
    logic [TOF_W-1:0]    tof_lat_q, tof_lat_d;
    logic [7:0]          run_q, run_d;
    logic [SAMPLE_W-1:0] peak_q, peak_d;

    logic [TOF_W-1:0]    blank_q, blank_d;
    logic [TOF_W-1:0]    max_q, max_d;
    logic [SAMPLE_W-1:0] thr_hi_q, thr_hi_d;
    logic [SAMPLE_W-1:0] thr_lo_q, thr_lo_d;
    logic [7:0]          mw_q, mw_d;

    logic                aboveHi, belowHi, belowLo, timeout, blankDone;
    logic [8:0]          runNext;
    logic [SAMPLE_W-1:0] peakWithSample;
    logic                emit;
    echo_result_t        emitRes;
    echo_result_t        slotRes;

    assign aboveHi        = sample_valid && (sample >= thr_hi_q);
    assign belowHi        = sample_valid && (sample <  thr_hi_q);
    assign belowLo        = sample_valid && (sample <  thr_lo_q);
    assign timeout        = (tof_q >= max_q);
    assign blankDone      = ({1'b0, tof_q} + 1'b1) >= {1'b0, blank_q};
    assign runNext        = {1'b0, run_q} + 9'd1;
    assign peakWithSample = sample_valid ? maxSample(peak_q, sample) : peak_q;

    // Next-state logic; a tx_start at the end overrides everything and silently aborts any measurement.
    always_comb begin
        state_d   = state_q;
        tof_d     = (tof_q == TOF_SAT) ? tof_q : tof_q + 1'b1;
        tof_lat_d = tof_lat_q;
        run_d     = run_q;
        peak_d    = peak_q;
        blank_d   = blank_q;
        max_d     = max_q;
        thr_hi_d  = thr_hi_q;
        thr_lo_d  = thr_lo_q;
        mw_d      = mw_q;
        emit      = 1'b0;
        emitRes   = '0;

        unique case (state_q)
            IDLE: begin
                tof_d = tof_q;
            end
            BLANK: begin
                if (blankDone) begin
                    state_d = LISTEN;
                end
            end
            LISTEN: begin
                if (aboveHi) begin
                    run_d = runNext[7:0];
                    if (run_q == 8'd0) begin
                        tof_lat_d = tof_q;
                        peak_d    = sample;
                    end else begin
                        peak_d = maxSample(peak_q, sample);
                    end
                    // Detection beats a coincident timeout.
                    if (runNext >= {1'b0, mw_q}) begin
                        state_d = PEAK;
                    end else if (timeout) begin
                        emit        = 1'b1;
                        emitRes.tof = max_q;
                    end
                end else begin
                    if (belowHi) begin
                        run_d = 8'd0;
                    end
                    if (timeout) begin
                        emit        = 1'b1;
                        emitRes.tof = max_q;
                    end
                end
                if (emit) begin
                    state_d = IDLE;
                    run_d   = 8'd0;
                    peak_d  = '0;
                end
            end
            PEAK: begin
                peak_d = peakWithSample;
                if (belowLo || timeout) begin
                    emit         = 1'b1;
                    emitRes.tof  = tof_lat_q;
                    emitRes.peak = peakWithSample;
                    emitRes.hit  = 1'b1;
                    state_d      = IDLE;
                    run_d        = 8'd0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (tx_start) begin
            emit      = 1'b0;
            state_d   = (blank_len == '0) ? LISTEN : BLANK;
            tof_d     = '0;
            tof_lat_d = '0;
            run_d     = 8'd0;
            peak_d    = '0;
            blank_d   = blank_len;
            max_d     = max_range;
            thr_hi_d  = thr_hi;
            thr_lo_d  = thr_lo;
            mw_d      = (min_width == 8'd0) ? 8'd1 : min_width;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tof_q     <= '0;
            tof_lat_q <= '0;
            run_q     <= 8'd0;
            peak_q    <= '0;
            blank_q   <= '0;
            max_q     <= '0;
            thr_hi_q  <= '0;
            thr_lo_q  <= '0;
            mw_q      <= 8'd1;
        end else begin
            state_q   <= state_d;
            tof_q     <= tof_d;
            tof_lat_q <= tof_lat_d;
            run_q     <= run_d;
            peak_q    <= peak_d;
            blank_q   <= blank_d;
            max_q     <= max_d;
            thr_hi_q  <= thr_hi_d;
            thr_lo_q  <= thr_lo_d;
            mw_q      <= mw_d;
        end
    end

    tof_result_slot #(
        .W($bits(echo_result_t))
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .push_i    (emit),
        .data_i    (emitRes),
        .ready_i   (res_ready),
        .valid_o   (res_valid),
        .data_o    (slotRes),
        .overrun_o (overrun)
    );

    assign busy     = (state_q != IDLE);
    assign res_tof  = slotRes.tof;
    assign res_peak = slotRes.peak;
    assign res_hit  = slotRes.hit;

endmodule
